// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state type, data width and wait-state limits.
package apb_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned MAX_WAIT = 15;
  localparam int unsigned CTR_W    = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_wait_ctr.sv
// Loadable wait-state down-counter; flags tell the completer when PREADY may rise.
module apb_wait_ctr
  import apb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CTR_W-1:0] load_val,
  input  logic             dec,
  output logic             zero_c,
  output logic             last_c
);

  logic [CTR_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CTR_W'(1);
    end
  end

  // last_c: the next decrement reaches zero, so PREADY rises at this edge
  assign zero_c = (count == '0);
  assign last_c = (count == CTR_W'(1));

endmodule

// File: rtl/apb_completer_mem.sv
// APB completer with an 8-bit register memory and WAIT_STATES access stretch.
// Define APB_COMPLETER_PSLVERR_EN to flag addresses >= DEPTH on PSLVERR.
module apb_completer_mem
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);

  localparam int unsigned      IDX_W   = $clog2(DEPTH);
  localparam logic [CTR_W-1:0] WS_LOAD = CTR_W'(WAIT_STATES);
  localparam bit               NO_WAIT = (WAIT_STATES == 0);

  apb_state_e       state;
  logic [IDX_W-1:0] idx_q;
  logic             oor_q;
  logic             write_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic             start_c;
  logic             busy_c;
  logic             step_c;
  logic             raise_c;
  logic             oor_c;
  logic             r_oor_c;
  logic             r_wr_c;
  logic [IDX_W-1:0] r_idx_c;
  logic             ctr_zero_c;
  logic             ctr_last_c;

`ifdef APB_COMPLETER_PSLVERR_EN
  assign oor_c = ({1'b0, PADDR} >= (ADDR_W + 1)'(DEPTH));
`else
  // Upper address bits are ignored: out-of-range addresses alias in range
  logic unused_addr_c;
  assign oor_c         = 1'b0;
  assign unused_addr_c = ^(PADDR >> IDX_W);
`endif

  // A setup phase may follow the previous completion with no idle cycle
  assign start_c = PSEL && !PENABLE;
  assign busy_c  = (state != ST_IDLE) && PSEL && PENABLE && !PREADY;
  assign step_c  = busy_c && (ctr_last_c || ctr_zero_c);
  assign raise_c = start_c ? NO_WAIT : step_c;

  // Transfer attributes at the edge that raises PREADY (live bus when no wait)
  assign r_idx_c = start_c ? PADDR[IDX_W-1:0] : idx_q;
  assign r_oor_c = start_c ? oor_c : oor_q;
  assign r_wr_c  = start_c ? PWRITE : write_q;

  apb_wait_ctr u_wait_ctr (
    .clk      (PCLK),
    .rst_n    (PRESETn),
    .load     (start_c),
    .load_val (WS_LOAD),
    .dec      (busy_c),
    .zero_c   (ctr_zero_c),
    .last_c   (ctr_last_c)
  );

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state   <= ST_IDLE;
      idx_q   <= '0;
      oor_q   <= 1'b0;
      write_q <= 1'b0;
      wdata_q <= '0;
      PRDATA  <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (start_c) begin
        state   <= ST_SETUP;
        idx_q   <= PADDR[IDX_W-1:0];
        oor_q   <= oor_c;
        write_q <= PWRITE;
        wdata_q <= PWDATA;
      end else if (state != ST_IDLE) begin
        if (!PSEL) begin
          state <= ST_IDLE;
        end else if (PREADY) begin
          if (write_q && !oor_q) begin
            mem[idx_q] <= wdata_q;
          end
          state <= ST_IDLE;
        end else begin
          state <= ST_ACCESS;
        end
      end

      // PREADY/PSLVERR pulse for one cycle; a dropped PSEL never raises them
      PREADY  <= raise_c;
      PSLVERR <= raise_c && r_oor_c;
      if (raise_c && !r_wr_c) begin
        PRDATA <= r_oor_c ? '0 : mem[r_idx_c];
      end
    end
  end

endmodule

// File: tb/tb_apb_completer_mem.sv
// Bench for apb_completer_mem: three instances (WAIT_STATES 1, 0, 3) against an array model.
module tb_apb_completer_mem;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       psel    [3];
  logic       penable [3];
  logic       pwrite  [3];
  logic [8:0] paddr   [3];
  logic [7:0] pwdata  [3];
  logic [7:0] prdata  [3];
  logic       pready  [3];
  logic       pslverr [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_completer_mem #(
      .ADDR_W      (9),
      .DEPTH       (256),
      .WAIT_STATES ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) u_dut (
      .PCLK    (clk),
      .PRESETn (rst_n),
      .PSEL    (psel[g]),
      .PENABLE (penable[g]),
      .PWRITE  (pwrite[g]),
      .PADDR   (paddr[g]),
      .PWDATA  (pwdata[g]),
      .PRDATA  (prdata[g]),
      .PREADY  (pready[g]),
      .PSLVERR (pslverr[g])
    );
  end

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
  endfunction

  // Reference model: one byte array per instance plus the last read value
  logic [7:0] m_mem  [3][256];
  logic [7:0] m_last [3];

  function automatic bit m_oor(input logic [8:0] a);
`ifdef APB_COMPLETER_PSLVERR_EN
    return (int'(a) >= 256);
`else
    return 1'b0;
`endif
  endfunction

  task automatic m_reset();
    for (int d = 0; d < 3; d++) begin
      m_last[d] = 8'h00;
      for (int i = 0; i < 256; i++) m_mem[d][i] = 8'h00;
    end
  endtask

  task automatic m_apply(input int d, input bit wr, input logic [8:0] a, input logic [7:0] wd,
                         output logic [7:0] erd, output bit eerr);
    int idx;
    idx  = int'(a) % 256;
    eerr = m_oor(a);
    if (eerr) begin
      if (!wr) m_last[d] = 8'h00;
    end else if (wr) begin
      m_mem[d][idx] = wd;
    end else begin
      m_last[d] = m_mem[d][idx];
    end
    erd = m_last[d];
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One APB transfer; entered and left 1 time unit after a rising edge
  task automatic xfer(input int d, input bit wr, input logic [8:0] a, input logic [7:0] wd,
                      input bit hold, output logic [7:0] rd, output logic err, output int nacc);
    psel[d]    = 1'b1;
    penable[d] = 1'b0;
    pwrite[d]  = wr;
    paddr[d]   = a;
    pwdata[d]  = wd;
    tick();
    penable[d] = 1'b1;
    nacc = 1;
    while (pready[d] !== 1'b1 && nacc < 40) begin
      tick();
      nacc++;
    end
    rd  = prdata[d];
    err = pslverr[d];
    tick();
    chk($sformatf("pready_pulse_d%0d_a%0d", d, a), 32'(pready[d]), 32'd0);
    if (!hold) begin
      psel[d]    = 1'b0;
      penable[d] = 1'b0;
    end
  endtask

  task automatic run_m(input int d, input bit wr, input logic [8:0] a, input logic [7:0] wd,
                       input bit hold);
    logic [7:0] rd, erd;
    logic       err;
    bit         eerr;
    int         nacc;
    xfer(d, wr, a, wd, hold, rd, err, nacc);
    m_apply(d, wr, a, wd, erd, eerr);
    chk($sformatf("acc_cycles_d%0d_a%0d", d, a), 32'(nacc), 32'(ws_of(d) + 1));
    chk($sformatf("prdata_d%0d_%s_a%0d", d, wr ? "wr" : "rd", a), 32'(rd), 32'(erd));
    chk($sformatf("pslverr_d%0d_a%0d", d, a), 32'(err), 32'(eerr));
  endtask

  typedef struct {
    int         d;
    bit         wr;
    logic [8:0] a;
    logic [7:0] wd;
    bit         hold;
    logic [7:0] erd;
    bit         eerr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int d, input bit wr, input logic [8:0] a, input logic [7:0] wd,
                     input bit hold, input logic [7:0] erd, input bit eerr);
    vec_t v;
    v.d = d; v.wr = wr; v.a = a; v.wd = wd; v.hold = hold; v.erd = erd; v.eerr = eerr;
    tbl.push_back(v);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rd, erd;
    logic       err;
    bit         eerr;
    int         nacc;
    int         d, k;
    logic [8:0] a;

    for (int i = 0; i < 3; i++) begin
      psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
      paddr[i] = '0; pwdata[i] = '0;
    end
    m_reset();

    // Power-on reset
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_prdata_d%0d", i), 32'(prdata[i]), 32'd0);
      chk($sformatf("rst_pready_d%0d", i), 32'(pready[i]), 32'd0);
      chk($sformatf("rst_pslverr_d%0d", i), 32'(pslverr[i]), 32'd0);
    end

    // Reset mid-write: memory and outputs return to zero, write not committed
    run_m(0, 1'b1, 9'd5, 8'h5A, 1'b0);
    run_m(0, 1'b0, 9'd5, 8'h00, 1'b0);
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 9'd5; pwdata[0] = 8'h33;
    tick();
    penable[0] = 1'b1;
    tick();
    rst_n = 1'b0;
    repeat (2) tick();
    chk("midrst_prdata", 32'(prdata[0]), 32'd0);
    chk("midrst_pready", 32'(pready[0]), 32'd0);
    chk("midrst_pslverr", 32'(pslverr[0]), 32'd0);
    rst_n = 1'b1;
    psel[0] = 1'b0; penable[0] = 1'b0;
    m_reset();
    tick();
    xfer(0, 1'b0, 9'd5, 8'h00, 1'b0, rd, err, nacc);
    chk("midrst_read5", 32'(rd), 32'd0);
    m_apply(0, 1'b0, 9'd5, 8'h00, erd, eerr);

    // Directed table: {inst, wr, addr, wdata, hold, expected PRDATA, expected PSLVERR}
    add(0, 1'b1, 9'd5,   8'd55,  1'b0, 8'd0,  1'b0);
    add(0, 1'b0, 9'd5,   8'd0,   1'b0, 8'd55, 1'b0);
    add(1, 1'b1, 9'd10,  8'd99,  1'b1, 8'd0,  1'b0);
    add(1, 1'b0, 9'd10,  8'd0,   1'b0, 8'd99, 1'b0);
`ifdef APB_COMPLETER_PSLVERR_EN
    add(0, 1'b1, 9'd260, 8'd123, 1'b0, 8'd55, 1'b1);
    add(0, 1'b0, 9'd260, 8'd0,   1'b0, 8'd0,  1'b1);
    add(0, 1'b0, 9'd4,   8'd0,   1'b0, 8'd0,  1'b0);
    add(2, 1'b1, 9'd300, 8'd200, 1'b0, 8'd0,  1'b1);
    add(2, 1'b0, 9'd44,  8'd0,   1'b0, 8'd0,  1'b0);
    add(2, 1'b1, 9'd255, 8'hA5,  1'b0, 8'd0,  1'b0);
    add(2, 1'b0, 9'd255, 8'd0,   1'b0, 8'hA5, 1'b0);
    add(2, 1'b0, 9'd256, 8'd0,   1'b0, 8'd0,  1'b1);
`else
    add(0, 1'b1, 9'd260, 8'd123, 1'b0, 8'd55,  1'b0);
    add(0, 1'b0, 9'd260, 8'd0,   1'b0, 8'd123, 1'b0);
    add(0, 1'b0, 9'd4,   8'd0,   1'b0, 8'd123, 1'b0);
    add(2, 1'b1, 9'd300, 8'd200, 1'b0, 8'd0,   1'b0);
    add(2, 1'b0, 9'd44,  8'd0,   1'b0, 8'd200, 1'b0);
    add(2, 1'b1, 9'd255, 8'hA5,  1'b0, 8'd200, 1'b0);
    add(2, 1'b0, 9'd255, 8'd0,   1'b0, 8'hA5,  1'b0);
    add(2, 1'b0, 9'd256, 8'd0,   1'b0, 8'd0,   1'b0);
`endif
    add(1, 1'b1, 9'd0,   8'h3C,  1'b1, 8'd99, 1'b0);
    add(1, 1'b0, 9'd0,   8'd0,   1'b0, 8'h3C, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      xfer(tbl[i].d, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].hold, rd, err, nacc);
      m_apply(tbl[i].d, tbl[i].wr, tbl[i].a, tbl[i].wd, erd, eerr);
      chk($sformatf("vec%0d_cycles", i), 32'(nacc), 32'(ws_of(tbl[i].d) + 1));
      chk($sformatf("vec%0d_prdata", i), 32'(rd), 32'(tbl[i].erd));
      chk($sformatf("vec%0d_pslverr", i), 32'(err), 32'(tbl[i].eerr));
    end

    // PSEL dropped after the first access cycle of a write: no PREADY, no commit
    run_m(2, 1'b1, 9'd7, 8'd11, 1'b0);
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 9'd7; pwdata[2] = 8'd77;
    tick();
    penable[2] = 1'b1;
    tick();
    psel[2] = 1'b0; penable[2] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("drop_pready_c%0d", i), 32'(pready[2]), 32'd0);
      tick();
    end
    xfer(2, 1'b0, 9'd7, 8'h00, 1'b0, rd, err, nacc);
    chk("drop_read7", 32'(rd), 32'd11);
    m_apply(2, 1'b0, 9'd7, 8'h00, erd, eerr);

    // Zero-wait instance: PSEL dropped while PREADY is already high
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 9'd7; pwdata[1] = 8'h44;
    tick();
    penable[1] = 1'b1;
    chk("ws0_drop_pready_hi", 32'(pready[1]), 32'd1);
    psel[1] = 1'b0; penable[1] = 1'b0;
    tick();
    chk("ws0_drop_pready_lo", 32'(pready[1]), 32'd0);
    run_m(1, 1'b0, 9'd7, 8'h00, 1'b0);

    // Randomized bursts, back-to-back within a burst, random idle gaps between
    for (int n = 0; n < 40; n++) begin
      d = $urandom_range(0, 2);
      k = $urandom_range(1, 3);
      for (int j = 0; j < k; j++) begin
        if ($urandom_range(0, 1) == 1)
          a = 9'($urandom_range(0, 511));
        else
          a = 9'($urandom_range(0, 15) + (($urandom_range(0, 1) == 1) ? 256 : 0));
        run_m(d, 1'($urandom_range(0, 1)), a, 8'($urandom), (j < k - 1));
      end
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
